fifo_pkt_drain: RTL and testbench

- Downstream consumer of the team's synchronous FIFO.
- Pops words from the FIFO's show-ahead read port and re-emits them on a registered valid/ready stream, grouped into fixed-length packets with a last flag.
- If a packet stalls mid-way because the FIFO runs dry for too long, the block completes the packet with pad words, so downstream framing never hangs.
- Sits between the FIFO and the packet sink, such as a serializer or bus master.

---
 rtl/fifo_pkt_drain.sv | 167 ++++++++++++++++
 tb/tb_fifo_pkt_drain.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_drain.sv
// Drains a show-ahead FIFO into a registered valid/ready stream of fixed-length
// packets, padding out any packet whose source stalls for TIMEOUT empty cycles.
module fifo_pkt_drain #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      PKT_LEN   = 4,
  parameter int unsigned      TIMEOUT   = 64,
  parameter logic [WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_data_rd,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             m_pad,
  output logic [15:0]      pkt_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAD    = 2'd2
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);
  localparam logic [15:0] TMO_IDX  = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [15:0]      timer_q, timer_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             m_pad_q, m_pad_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic             busy_q, busy_d;

  logic             load_en_s;
  logic             fifo_issue_s;
  logic             pad_issue_s;
  logic             issue_s;

  // Next-state, stall timer, output-register load and pop strobe.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timer_d   = timer_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_pad_d   = m_pad_q;

    load_en_s = ~m_valid_q | m_ready;
    if (state_q == ST_PAD) begin
      pad_issue_s  = load_en_s & ~flush;
      fifo_issue_s = 1'b0;
    end else begin
      pad_issue_s  = 1'b0;
      fifo_issue_s = load_en_s & ~fifo_empty & ~flush;
    end
    issue_s = fifo_issue_s | pad_issue_s;

    if (m_valid_q & m_ready & m_last_q) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end

    if (flush) begin
      state_d   = ST_IDLE;
      wcnt_d    = 16'd0;
      timer_d   = 16'd0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      m_pad_d   = 1'b0;
    end else begin
      // Only an empty FIFO advances the timer; a blocked but non-empty pop holds it.
      case (state_q)
        ST_ACTIVE: begin
          if (fifo_issue_s) begin
            timer_d = 16'd0;
          end else if (fifo_empty) begin
            if (timer_q == TMO_IDX) begin
              timer_d = 16'd0;
              state_d = ST_PAD;
            end else begin
              timer_d = timer_q + 16'd1;
            end
          end else begin
            timer_d = timer_q;
          end
        end
        ST_IDLE, ST_PAD: begin
          timer_d = 16'd0;
        end
        default: begin
          timer_d = 16'd0;
          state_d = ST_IDLE;
        end
      endcase

      if (issue_s) begin
        m_valid_d = 1'b1;
        m_pad_d   = pad_issue_s;
        m_data_d  = pad_issue_s ? PAD_VALUE : fifo_data_rd;
        if (wcnt_q == LAST_IDX) begin
          m_last_d = 1'b1;
          wcnt_d   = 16'd0;
          state_d  = ST_IDLE;
        end else begin
          m_last_d = 1'b0;
          wcnt_d   = wcnt_q + 16'd1;
          state_d  = pad_issue_s ? ST_PAD : ST_ACTIVE;
        end
      end else if (load_en_s) begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        m_pad_d   = 1'b0;
      end else begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_pad_d   = m_pad_q;
      end
    end

    fifo_pop = fifo_issue_s & ~rst;
    busy_d   = (state_d != ST_IDLE) | m_valid_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 16'd0;
      timer_q   <= 16'd0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_pad_q   <= 1'b0;
      pkt_cnt_q <= 16'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timer_q   <= timer_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_pad_q   <= m_pad_d;
      pkt_cnt_q <= pkt_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_pad   = m_pad_q;
  assign pkt_cnt = pkt_cnt_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Directed and randomized bench for fifo_pkt_drain against a packet-level
// reference model that also owns the upstream FIFO contents.
module tb_fifo_pkt_drain;

  localparam int          WIDTH     = 16;
  localparam int          PKT_LEN   = 4;
  localparam int          TIMEOUT   = 64;
  localparam logic [15:0] PAD_VALUE = 16'h0000;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  fifo_data_rd;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              flush;
  logic [WIDTH-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              m_pad;
  logic [15:0]       pkt_cnt;
  logic              busy;

  fifo_pkt_drain #(
    .WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT), .PAD_VALUE(PAD_VALUE)
  ) dut (
    .clk(clk), .rst(rst), .fifo_data_rd(fifo_data_rd), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop), .flush(flush), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .m_pad(m_pad), .pkt_cnt(pkt_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents, expected output register, packet position,
  // length of the current empty stall, and whether the packet is being padded.
  logic [15:0] fq[$];
  bit          mv, ml, mp;
  logic [15:0] md;
  logic [15:0] exp_cnt;
  int          pos;
  int          stall;
  bit          padding;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv = 1'b0; ml = 1'b0; mp = 1'b0; md = 16'h0000;
    exp_cnt = 16'd0; pos = 0; stall = 0; padding = 1'b0;
  endtask

  task automatic model_step(input bit rdy, input bit fl, input bit pop);
    bit can_load;
    bit empty0;
    int pos0;
    bit pad0;
    can_load = !mv || rdy;
    empty0   = (fq.size() == 0);
    pos0     = pos;
    pad0     = padding;
    if (mv && rdy && ml) exp_cnt = exp_cnt + 16'd1;
    if (fl) begin
      mv = 1'b0; ml = 1'b0; mp = 1'b0;
      pos = 0; stall = 0; padding = 1'b0;
    end else begin
      if ((pad0 && can_load) || pop) begin
        if (pad0) md = PAD_VALUE;
        else      md = fq.pop_front();
        mv = 1'b1;
        mp = pad0;
        ml = (pos0 == PKT_LEN - 1);
        pos = (pos0 + 1) % PKT_LEN;
        if (pos == 0) padding = 1'b0;
      end else if (can_load) begin
        mv = 1'b0; ml = 1'b0; mp = 1'b0;
      end
      if (pos0 == 0 || pad0 || pop) begin
        stall = 0;
      end else if (empty0) begin
        if (stall == TIMEOUT - 1) begin
          padding = 1'b1;
          stall   = 0;
        end else begin
          stall++;
        end
      end
    end
  endtask

  task automatic tick(input bit rdy, input bit fl);
    bit ep;
    m_ready    = rdy;
    flush      = fl;
    fifo_empty = (fq.size() == 0);
    fifo_data_rd = (fq.size() != 0) ? fq[0] : 16'($urandom);
    #1;
    ep = !padding && (!mv || rdy) && (fq.size() != 0) && !fl;
    check("fifo_pop", 32'(fifo_pop), 32'(ep));
    @(posedge clk);
    model_step(rdy, fl, ep);
    #1;
    check("m_valid", 32'(m_valid), 32'(mv));
    if (mv) check("m_data", 32'(m_data), 32'(md));
    check("m_last", 32'(m_last), 32'(ml));
    check("m_pad", 32'(m_pad), 32'(mp));
    check("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
    check("busy", 32'(busy), 32'((pos != 0) || padding || mv));
  endtask

  initial begin
    int mode;
    int prob;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b0; fifo_data_rd = 16'h1234;
    model_reset();
    #2;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_pad", 32'(m_pad), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_fifo_pop", 32'(fifo_pop), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Smooth stream of eight words.
    for (int i = 1; i <= 8; i++) fq.push_back(16'(i));
    repeat (10) tick(1'b1, 1'b0);
    check("smooth_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Backpressure with 0x0002 held on the output.
    for (int i = 1; i <= 4; i++) fq.push_back(16'(i));
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      check("bp_hold_data", 32'(m_data), 32'h0002);
    end
    repeat (4) tick(1'b1, 1'b0);
    check("bp_pkt_cnt", 32'(pkt_cnt), 32'd3);

    // Timeout padding after two words, with a word arriving during PAD.
    fq.push_back(16'h0011);
    fq.push_back(16'h0012);
    repeat (2) tick(1'b1, 1'b0);
    repeat (64) tick(1'b1, 1'b0);
    check("tmo_no_pad_yet", 32'(m_pad), 32'd0);
    fq.push_back(16'h0099);
    tick(1'b1, 1'b0);
    check("tmo_pad1", 32'(m_pad), 32'd1);
    check("tmo_pad1_data", 32'(m_data), 32'h0000);
    tick(1'b1, 1'b0);
    check("tmo_pad2_last", 32'(m_last), 32'd1);
    tick(1'b1, 1'b0);
    check("tmo_next_word", 32'(m_data), 32'h0099);
    check("tmo_pkt_cnt", 32'(pkt_cnt), 32'd4);
    for (int i = 0; i < 3; i++) fq.push_back(16'(16'h00A0 + 16'(i)));
    repeat (4) tick(1'b1, 1'b0);

    // Word arrives exactly when the stall timer sits at TIMEOUT-1.
    fq.push_back(16'h0031);
    fq.push_back(16'h0032);
    repeat (2) tick(1'b1, 1'b0);
    repeat (63) tick(1'b1, 1'b0);
    fq.push_back(16'h00AA);
    tick(1'b1, 1'b0);
    check("race_data", 32'(m_data), 32'h00AA);
    check("race_pad", 32'(m_pad), 32'd0);
    repeat (3) tick(1'b1, 1'b0);
    fq.push_back(16'h00AB);
    repeat (3) tick(1'b1, 1'b0);

    // Flush while the third word of a packet is stalled.
    for (int i = 0; i < 7; i++) fq.push_back(16'(16'h0021 + 16'(i)));
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("flush_valid", 32'(m_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    repeat (6) tick(1'b1, 1'b0);

    // Asynchronous reset mid-packet.
    for (int i = 0; i < 6; i++) fq.push_back(16'(16'h0041 + 16'(i)));
    repeat (2) tick(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_last", 32'(m_last), 32'd0);
    check("arst_pad", 32'(m_pad), 32'd0);
    check("arst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("arst_pop", 32'(fifo_pop), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    repeat (8) tick(1'b1, 1'b0);

    // Randomized traffic with phases of dense, sparse and gapped arrivals.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) mode = int'($urandom_range(0, 2));
      case (mode)
        0:       prob = 70;
        1:       prob = 10;
        default: prob = ((i % 250) < 120) ? 0 : 60;
      endcase
      if (fq.size() < 16 && int'($urandom_range(0, 99)) < prob) fq.push_back(16'($urandom));
      tick(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
